// File: rtl/sstv_ram_arbiter.sv
// Arbitrates the single-port SSTV frame RAM between VGA reads (highest priority),
// a frame zero-fill sequencer, and a small FIFO of SSTV writer pixels.
module sstv_ram_arbiter #(
  parameter int PIXELS     = 19200,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [1:0]        wr_data_i,
  input  logic              vga_rd_en_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [1:0]        vga_data_o,
  output logic              vga_valid_o,
  input  logic              clear_req_i,
  output logic              clear_busy_o,
  output logic              err_addr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [1:0]        ram_wdata_o,
  input  logic [1:0]        ram_rdata_i
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);
  localparam logic [PTR_W:0]    FULL_XOR = {1'b1, {PTR_W{1'b0}}};

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [1:0]        fifo_data_q [FIFO_DEPTH];
  logic [PTR_W:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic              wr_ready_q, wr_ready_d;
  logic              err_q, err_d;

  logic              vld_p0_q, vld_p1_q;
  logic [1:0]        data_p1_q;

  logic              accept, push, pop, clr_wr, empty, addr_ok;

  assign addr_ok = (wr_addr_i <= LAST_PIX);
  assign accept  = wr_valid_i && wr_ready_q;
  assign push    = accept && addr_ok;
  assign empty   = (wptr_q == rptr_q);

  // Port grant: VGA read, then clear write, then FIFO drain (IDLE only)
  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = 2'b00;
    pop         = 1'b0;
    clr_wr      = 1'b0;
    if (vga_rd_en_i) begin
      ram_addr_o = vga_addr_i;
    end else if (!reset && state_q == S_CLEAR) begin
      ram_addr_o = clr_ptr_q;
      ram_we_o   = 1'b1;
      clr_wr     = 1'b1;
    end else if (!reset && !empty) begin
      ram_addr_o  = fifo_addr_q[rptr_q[PTR_W-1:0]];
      ram_wdata_o = fifo_data_q[rptr_q[PTR_W-1:0]];
      ram_we_o    = 1'b1;
      pop         = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req_i) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_wr) begin
          if (clr_ptr_q == LAST_PIX) state_d = S_IDLE;
          else                       clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d     = wptr_q + {{PTR_W{1'b0}}, push};
    rptr_d     = rptr_q + {{PTR_W{1'b0}}, pop};
    wr_ready_d = ((wptr_d ^ rptr_d) != FULL_XOR);
    err_d      = err_q || (accept && !addr_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clr_ptr_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_ready_q <= wr_ready_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q[PTR_W-1:0]] <= wr_addr_i;
      fifo_data_q[wptr_q[PTR_W-1:0]] <= wr_data_i;
    end
  end

  // Read pipeline: p0 = RAM access issued, p1 = RAM data captured
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= 2'b00;
    end else begin
      vld_p0_q <= vga_rd_en_i;
      vld_p1_q <= vld_p0_q;
      if (vld_p0_q) data_p1_q <= ram_rdata_i;
    end
  end

  assign wr_ready_o   = wr_ready_q;
  assign err_addr_o   = err_q;
  assign clear_busy_o = (state_q == S_CLEAR);
  assign vga_valid_o  = vld_p1_q;
  assign vga_data_o   = data_p1_q;

endmodule
